// File: rtl/mcounter_csr_pkg.sv
// Shared definitions for the machine counter CSR block: CSR addresses,
// Zicsr operation decode and the request FSM state encoding.
package mcounter_csr_pkg;

  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

  localparam logic [31:0] INHIBIT_MASK = 32'h0000_0005;

  typedef enum logic [1:0] {
    OP_ILL = 2'd0,
    OP_RW  = 2'd1,
    OP_RS  = 2'd2,
    OP_RC  = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Register and immediate forms share the same operation in bits [1:0].
  function automatic csr_op_e decode_op(input logic [2:0] funct3);
    csr_op_e op;
    case (funct3)
      3'b001, 3'b101: op = OP_RW;
      3'b010, 3'b110: op = OP_RS;
      3'b011, 3'b111: op = OP_RC;
      default:        op = OP_ILL;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] apply_op(input csr_op_e op,
                                           input logic [31:0] old_val,
                                           input logic [31:0] arg);
    logic [31:0] res;
    case (op)
      OP_RW:   res = arg;
      OP_RS:   res = old_val | arg;
      OP_RC:   res = old_val & ~arg;
      default: res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mcounter_csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// A write to either half wins over the increment for that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  // Counter state: reset, half-word write, or full 64-bit increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= 64'h0;
    end else if (wr_lo) begin
      value[31:0] <= wdata;
    end else if (wr_hi) begin
      value[63:32] <= wdata;
    end else if (inc) begin
      value <= value + 64'h1;
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/mcounter_csr.sv
// Machine counter CSR block: mcycle, minstret and mcountinhibit behind a
// three-state request/response CSR access port.
module mcounter_csr #(
  parameter logic [31:0] INHIBIT_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_retire,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] cycle_o,
  output logic [63:0] instret_o
);
  import mcounter_csr_pkg::*;

  state_e      state;
  logic [11:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic        inh_cy;
  logic        inh_ir;

  logic [63:0] cycle_val;
  logic [63:0] instret_val;

  csr_op_e     op;
  logic        addr_ok;
  logic        legal;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        do_write;
  logic        wr_cyc_lo;
  logic        wr_cyc_hi;
  logic        wr_ins_lo;
  logic        wr_ins_hi;
  logic        wr_inh;

  // Decode the latched request and form the read-modify-write result.
  always_comb begin
    op      = decode_op(funct3_q);
    addr_ok = 1'b1;
    old_val = 32'h0;
    case (addr_q)
      CSR_MCYCLE:        old_val = cycle_val[31:0];
      CSR_MCYCLEH:       old_val = cycle_val[63:32];
      CSR_MINSTRET:      old_val = instret_val[31:0];
      CSR_MINSTRETH:     old_val = instret_val[63:32];
      CSR_MCOUNTINHIBIT: old_val = {29'h0, inh_ir, 1'b0, inh_cy};
      default:           addr_ok = 1'b0;
    endcase
    legal   = addr_ok && (op != OP_ILL);
    new_val = apply_op(op, old_val, wdata_q);
    // Set/clear with a zero mask is a pure read and must not disturb the CSR.
    if ((state == ST_EXEC) && legal && ((op == OP_RW) || (wdata_q != 32'h0))) begin
      do_write = 1'b1;
    end else begin
      do_write = 1'b0;
    end
  end

  // Per-CSR write strobes, live only during EXEC.
  always_comb begin
    wr_cyc_lo = do_write && (addr_q == CSR_MCYCLE);
    wr_cyc_hi = do_write && (addr_q == CSR_MCYCLEH);
    wr_ins_lo = do_write && (addr_q == CSR_MINSTRET);
    wr_ins_hi = do_write && (addr_q == CSR_MINSTRETH);
    wr_inh    = do_write && (addr_q == CSR_MCOUNTINHIBIT);
  end

  csr_counter64 u_cycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (!inh_cy),
    .wr_lo (wr_cyc_lo),
    .wr_hi (wr_cyc_hi),
    .wdata (new_val),
    .value (cycle_val)
  );

  csr_counter64 u_instret (
    .clk   (clk),
    .rst   (rst),
    .inc   (inst_retire && !inh_ir),
    .wr_lo (wr_ins_lo),
    .wr_hi (wr_ins_hi),
    .wdata (new_val),
    .value (instret_val)
  );

  assign cycle_o   = cycle_val;
  assign instret_o = instret_val;

  // Only the two implemented inhibit bits are stored; the rest read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      inh_cy <= INHIBIT_RST[0];
      inh_ir <= INHIBIT_RST[2];
    end else if (wr_inh) begin
      inh_cy <= new_val[0];
      inh_ir <= new_val[2];
    end else begin
      inh_cy <= inh_cy;
      inh_ir <= inh_ir;
    end
  end

  // Request FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      addr_q     <= 12'h0;
      funct3_q   <= 3'h0;
      wdata_q    <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            funct3_q  <= req_funct3;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_valid <= 1'b1;
          resp_rdata <= legal ? old_val : 32'h0;
          resp_err   <= !legal;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcounter_csr.sv
// Scoreboard bench for mcounter_csr: a transaction-level counter model
// predicts responses and live counter values under random CSR traffic.
module tb_mcounter_csr;

  localparam logic [31:0] INH = 32'h0;

  logic        clk;
  logic        rst;
  logic        inst_retire;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [63:0] cycle_o;
  logic [63:0] instret_o;

  mcounter_csr #(.INHIBIT_RST(INH)) dut (
    .clk(clk), .rst(rst), .inst_retire(inst_retire),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .cycle_o(cycle_o), .instret_o(instret_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_total = 0;

  logic [63:0] m_cyc, m_ins;
  logic [31:0] m_inh;
  bit          pend;
  logic [11:0] p_addr;
  logic [2:0]  p_f3;
  logic [31:0] p_wd;
  logic [32:0] exp_q[$];
  bit          chk_on = 1'b0;
  int          retire_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: one call per rising edge, working from CSR semantics.
  task automatic model_step();
    logic [63:0] c_n, i_n;
    logic [31:0] inh_n, old, nv;
    bit legal;
    if (rst) begin
      m_cyc = 64'd0; m_ins = 64'd0; m_inh = INH & 32'd5;
      pend = 1'b0; exp_q.delete();
      return;
    end
    c_n   = m_inh[0] ? m_cyc : m_cyc + 64'd1;
    i_n   = (inst_retire && !m_inh[2]) ? m_ins + 64'd1 : m_ins;
    inh_n = m_inh;
    if (pend) begin
      legal = (p_f3 != 3'b000) && (p_f3 != 3'b100);
      case (p_addr)
        12'hB00: old = m_cyc[31:0];
        12'hB80: old = m_cyc[63:32];
        12'hB02: old = m_ins[31:0];
        12'hB82: old = m_ins[63:32];
        12'h320: old = m_inh;
        default: begin old = 32'd0; legal = 1'b0; end
      endcase
      if (!legal) begin
        exp_q.push_back({1'b1, 32'd0});
      end else begin
        exp_q.push_back({1'b0, old});
        case (p_f3[1:0])
          2'b01:   nv = p_wd;
          2'b10:   nv = old | p_wd;
          default: nv = old & ~p_wd;
        endcase
        if (p_f3[1:0] == 2'b01 || p_wd != 32'd0) begin
          case (p_addr)
            12'hB00: c_n = {m_cyc[63:32], nv};
            12'hB80: c_n = {nv, m_cyc[31:0]};
            12'hB02: i_n = {m_ins[63:32], nv};
            12'hB82: i_n = {nv, m_ins[31:0]};
            default: inh_n = nv & 32'd5;
          endcase
        end
      end
    end
    m_cyc = c_n; m_ins = i_n; m_inh = inh_n;
    pend = req_valid && req_ready;
    if (pend) begin p_addr = req_addr; p_f3 = req_funct3; p_wd = req_wdata; end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    case (retire_mode)
      0:       inst_retire = 1'b0;
      1:       inst_retire = 1'b1;
      default: inst_retire = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: live counters every cycle, responses whenever a handshake occurs.
  initial forever begin
    logic [32:0] e;
    @(negedge clk);
    #1;
    if (chk_on && !rst) begin
      check("cycle_o", cycle_o, m_cyc);
      check("instret_o", instret_o, m_ins);
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL resp_unexpected: got rdata %h err %b expected no response", resp_rdata, resp_err);
        end else begin
          e = exp_q.pop_front();
          check("resp_err", {63'd0, resp_err}, {63'd0, e[32]});
          check("resp_rdata", {32'd0, resp_rdata}, {32'd0, e[31:0]});
        end
      end
    end
  end

  task automatic issue_req(input logic [11:0] a, input logic [2:0] f, input logic [31:0] d);
    int n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      n_total++;
      $display("FAIL req_ready_timeout: got req_ready 0 expected 1");
    end
    req_valid = 1'b1; req_addr = a; req_funct3 = f; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = 12'($urandom); req_funct3 = 3'($urandom); req_wdata = $urandom;
  endtask

  task automatic finish_resp(input int hold);
    int n = 0;
    resp_ready = 1'b0;
    repeat (hold) @(negedge clk);
    resp_ready = 1'b1;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    if (!resp_valid) begin
      n_total++;
      $display("FAIL resp_valid_timeout: got resp_valid 0 expected 1");
    end
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic do_req(input logic [11:0] a, input logic [2:0] f, input logic [31:0] d, input int hold);
    issue_req(a, f, d);
    finish_resp(hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] frozen_c, frozen_i;
    logic [11:0] addrs[6];
    rst = 1'b1; req_valid = 1'b0; req_addr = 12'h0; req_funct3 = 3'h0;
    req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_err", {63'd0, resp_err}, 64'd0);
    check("rst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
    check("rst_cycle", cycle_o, 64'd0);
    check("rst_instret", instret_o, 64'd0);
    rst = 1'b0; chk_on = 1'b1;
    repeat (10) @(negedge clk);
    check("idle10_cycle", cycle_o, 64'd10);
    check("idle10_instret", instret_o, 64'd0);
    check("idle10_req_ready", {63'd0, req_ready}, 64'd1);

    // Low-half write followed by carry into the high half.
    issue_req(12'hB00, 3'b001, 32'hFFFF_FFFF);
    @(negedge clk);
    check("rw_mcycle_written", cycle_o, 64'h0000_0000_FFFF_FFFF);
    @(negedge clk);
    check("rw_mcycle_carry", cycle_o, 64'h0000_0001_0000_0000);
    finish_resp(0);

    // Inhibit both counters; masked bit 1 must not stick.
    retire_mode = 1;
    do_req(12'h320, 3'b010, 32'h0000_0007, 0);
    frozen_c = m_cyc; frozen_i = m_ins;
    repeat (4) @(negedge clk);
    check("inhibit_cycle_frozen", cycle_o, frozen_c);
    check("inhibit_instret_frozen", instret_o, frozen_i);
    do_req(12'h320, 3'b110, 32'h0, 1);
    do_req(12'h320, 3'b011, 32'hFFFF_FFFF, 0);

    // Zero-mask clear is a read while minstret keeps counting.
    do_req(12'hB02, 3'b111, 32'h0, 1);
    retire_mode = 2;

    // Illegal address and illegal funct3.
    do_req(12'hC00, 3'b001, $urandom, 0);
    do_req(12'hB00, 3'b100, $urandom, 2);
    do_req(12'hB82, 3'b000, $urandom, 0);

    // Full 64-bit wrap of both counters.
    retire_mode = 1;
    do_req(12'hB80, 3'b001, 32'hFFFF_FFFF, 0);
    do_req(12'hB00, 3'b101, 32'hFFFF_FFF8, 0);
    do_req(12'hB82, 3'b001, 32'hFFFF_FFFF, 0);
    do_req(12'hB02, 3'b001, 32'hFFFF_FFFA, 0);
    repeat (12) @(negedge clk);
    retire_mode = 2;

    // Reset while the response is stalled.
    issue_req(12'hB02, 3'b010, 32'h0);
    resp_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("stall_resp_valid", {63'd0, resp_valid}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_resp_dropped", {63'd0, resp_valid}, 64'd0);
    check("rst_mid_req_ready", {63'd0, req_ready}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("post_rst_resp_valid", {63'd0, resp_valid}, 64'd0);

    addrs[0] = 12'hB00; addrs[1] = 12'hB80; addrs[2] = 12'hB02;
    addrs[3] = 12'hB82; addrs[4] = 12'h320; addrs[5] = 12'h000;
    for (int i = 0; i < 150; i++) begin
      logic [11:0] a;
      logic [31:0] d;
      a = addrs[$urandom_range(0, 5)];
      if (a == 12'h000) a = 12'($urandom);
      d = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if (i % 37 == 36) begin
        // Reset during EXEC: the pending write must be discarded.
        issue_req(a, 3'($urandom_range(0, 7)), d);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        do_req(a, 3'($urandom_range(0, 7)), d, $urandom_range(0, 3));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
